// File: rtl/seg_pkg.sv
// Shared seven-segment code table.
// The same table serves the forward hex-to-segment encoder and the reverse
// decoder, so both directions stay consistent.
// Patterns are active-low: bit 6 = g ... bit 0 = a.
package seg_pkg;

  localparam int SEG_W    = 7;
  localparam int VALUE_W  = 4;
  localparam int NUM_CODE = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Index i holds the pattern that displays hex digit i.
  localparam logic [SEG_W-1:0] SEG_CODE [NUM_CODE] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Result of a reverse lookup on one pattern.
  typedef struct packed {
    logic               hit;    // pattern is one of SEG_CODE
    logic               blank;  // pattern is SEG_BLANK
    logic [VALUE_W-1:0] value;  // decoded digit, valid when hit
  } seg_lookup_t;

endpackage

// File: rtl/seg_lookup.sv
// Combinational reverse lookup: segment pattern -> {hit, blank, value}.
// Ports:
//   seg_i    : active-low segment pattern
//   result_o : lookup result (hit / blank flags and decoded value)
module seg_lookup
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output seg_lookup_t      result_o
);

  // NOTE: every field gets a default before the search so no path leaves
  // result_o unassigned, which would otherwise infer a latch.
  always_comb begin
    result_o       = '0;
    result_o.blank = (seg_i == SEG_BLANK);
    for (int i = 0; i < NUM_CODE; i++) begin
      if (seg_i == SEG_CODE[i]) begin
        result_o.hit   = 1'b1;
        result_o.value = VALUE_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Glitch-filtered seven-segment pattern decoder.
// A pattern must be seen on STABLE_CYCLES consecutive enabled samples before
// it is classified once: legal codes go to a one-entry valid/ready output
// register, blank is ignored, anything else pulses seg_err_o. A legal digit
// that finds the output register full is dropped and pulses overrun_o.
// Ports:
//   clk_i          : clock, rising edge
//   reset_i        : synchronous active-high reset
//   seg_in_i       : active-low segment pattern (bit 6 = g ... bit 0 = a)
//   sample_en_i    : seg_in_i is sampled only when high
//   digit_out_o    : decoded value, held while digit_valid_o is high
//   digit_valid_o  : digit_out_o is valid
//   digit_ready_i  : consumer accepts on digit_valid_o && digit_ready_i
//   seg_err_o      : one-cycle pulse, stable pattern was illegal
//   overrun_o      : one-cycle pulse, decoded digit dropped (register full)
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4  // legal range 1..15
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [SEG_W-1:0]   seg_in_i,
  input  logic               sample_en_i,
  output logic [VALUE_W-1:0] digit_out_o,
  output logic               digit_valid_o,
  input  logic               digit_ready_i,
  output logic               seg_err_o,
  output logic               overrun_o
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_PRE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [SEG_W-1:0]   cur_pat_q, cur_pat_d;
  logic [CW-1:0]      stab_cnt_q, stab_cnt_d;
  logic [VALUE_W-1:0] digit_q, digit_d;
  logic               valid_q, valid_d;
  logic               seg_err_q, seg_err_d;
  logic               overrun_q, overrun_d;
  logic               emit;
  seg_lookup_t        lookup;

  // The input is classified directly: on an emit it either equals cur_pat_q
  // (stability reached) or is the new pattern (STABLE_CYCLES == 1).
  seg_lookup u_lookup (
    .seg_i    (seg_in_i),
    .result_o (lookup)
  );

  always_comb begin
    cur_pat_d  = cur_pat_q;
    stab_cnt_d = stab_cnt_q;
    digit_d    = digit_q;
    valid_d    = valid_q;
    seg_err_d  = 1'b0;
    overrun_d  = 1'b0;
    emit       = 1'b0;

    // Stability filter; disabled cycles freeze the count.
    if (sample_en_i) begin
      if (seg_in_i == cur_pat_q) begin
        if (stab_cnt_q != CNT_MAX) stab_cnt_d = stab_cnt_q + CNT_ONE;
        // Saturation keeps this true for one sample only per stable pattern.
        emit = (stab_cnt_q == CNT_PRE);
      end else begin
        cur_pat_d  = seg_in_i;
        stab_cnt_d = CNT_ONE;
        emit       = (STABLE_CYCLES == 1);
      end
    end

    // Consumer handshake; a same-cycle load below re-asserts valid.
    if (valid_q && digit_ready_i) valid_d = 1'b0;

    if (emit) begin
      if (lookup.hit) begin
        if (!valid_q || digit_ready_i) begin
          digit_d = lookup.value;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (!lookup.blank) begin
        seg_err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cur_pat_q  <= SEG_BLANK;
      stab_cnt_q <= '0;
      digit_q    <= '0;
      valid_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cur_pat_q  <= cur_pat_d;
      stab_cnt_q <= stab_cnt_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      seg_err_q  <= seg_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign digit_out_o   = digit_q;
  assign digit_valid_o = valid_q;
  assign seg_err_o     = seg_err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Self-checking bench for seg_pattern_decoder: two instances (4-sample and
// 1-sample filters) share the same stimulus and are compared every cycle
// against a behavioural model based on run lengths of identical samples.
module tb_seg_pattern_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       sample_en;
  logic       digit_ready;

  logic [3:0] dig   [2];
  logic       valid [2];
  logic       err   [2];
  logic       ovr   [2];

  localparam int NSTAB [2] = '{4, 1};

  always #5 clk = ~clk;

  seg_pattern_decoder #(.STABLE_CYCLES(4)) u_dut4 (
    .clk_i         (clk),
    .reset_i       (reset),
    .seg_in_i      (seg_in),
    .sample_en_i   (sample_en),
    .digit_out_o   (dig[0]),
    .digit_valid_o (valid[0]),
    .digit_ready_i (digit_ready),
    .seg_err_o     (err[0]),
    .overrun_o     (ovr[0])
  );

  seg_pattern_decoder #(.STABLE_CYCLES(1)) u_dut1 (
    .clk_i         (clk),
    .reset_i       (reset),
    .seg_in_i      (seg_in),
    .sample_en_i   (sample_en),
    .digit_out_o   (dig[1]),
    .digit_valid_o (valid[1]),
    .digit_ready_i (digit_ready),
    .seg_err_o     (err[1]),
    .overrun_o     (ovr[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Digit shapes from the display table, active-low, g..a.
  localparam logic [6:0] CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  // Returns the digit value, 16 for blank, -1 for an illegal shape.
  function automatic int decode(input logic [6:0] p);
    if (p == BLANK) return 16;
    for (int i = 0; i < 16; i++) if (CODES[i] == p) return i;
    return -1;
  endfunction

  // Model: length of the current run of identical enabled samples.
  logic [6:0] m_pat   [2];
  int         m_len   [2];
  logic       m_valid [2];
  logic [3:0] m_dig   [2];
  logic       m_err   [2];
  logic       m_ovr   [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pat[k] = BLANK; m_len[k] = 0; m_valid[k] = 0;
        m_dig[k] = 0; m_err[k] = 0; m_ovr[k] = 0;
      end else begin
        bit emit = 0;
        bit was_valid = m_valid[k];
        bit loaded = 0;
        int v;
        m_err[k] = 0; m_ovr[k] = 0;
        if (sample_en) begin
          if (seg_in == m_pat[k]) m_len[k]++;
          else begin m_pat[k] = seg_in; m_len[k] = 1; end
          emit = (m_len[k] == NSTAB[k]);
        end
        if (emit) begin
          v = decode(seg_in);
          if (v >= 0 && v < 16) begin
            if (!was_valid || digit_ready) begin
              m_dig[k] = 4'(v); m_valid[k] = 1; loaded = 1;
            end else m_ovr[k] = 1;
          end else if (v < 0) m_err[k] = 1;
        end
        if (!loaded && was_valid && digit_ready) m_valid[k] = 0;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      string s = (k == 0) ? "n4" : "n1";
      check({s, "_valid"},   valid[k], m_valid[k]);
      check({s, "_digit"},   dig[k],   m_dig[k]);
      check({s, "_seg_err"}, err[k],   m_err[k]);
      check({s, "_overrun"}, ovr[k],   m_ovr[k]);
    end
  endtask

  // One clock: inputs driven away from the edge, model advanced at the
  // edge, outputs sampled 1 time unit later.
  task automatic step(input logic [6:0] s, input logic en, input logic rdy, input logic rst);
    @(negedge clk);
    seg_in = s; sample_en = en; digit_ready = rdy; reset = rst;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic hold(input logic [6:0] s, input int n, input logic rdy = 1'b1);
    for (int i = 0; i < n; i++) step(s, 1'b1, rdy, 1'b0);
  endtask

  int valid_pulses;

  initial begin
    reset = 1'b1; seg_in = BLANK; sample_en = 1'b0; digit_ready = 1'b1;
    step(BLANK, 1'b1, 1'b1, 1'b1);
    step(BLANK, 1'b1, 1'b1, 1'b1);

    // Digit 9 held: one emit only.
    valid_pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step(CODES[9], 1'b1, 1'b1, 1'b0);
      if (valid[0]) valid_pulses++;
    end
    check("n4_single_emit_9", valid_pulses, 1);

    // Glitch inside a hold of 3.
    hold(CODES[3], 2); hold(CODES[1], 1); hold(CODES[3], 4); hold(BLANK, 4);

    // Same digit twice via blank.
    hold(CODES[5], 4); hold(BLANK, 4); hold(CODES[5], 4); hold(BLANK, 4);

    // Illegal pattern.
    hold(7'b1111110, 5); hold(BLANK, 4);

    // Overrun with consumer stalled, then drain.
    hold(CODES[2], 4, 1'b0); hold(BLANK, 4, 1'b0); hold(CODES[7], 5, 1'b0);
    check("n4_held_digit", dig[0], 4'h2);
    hold(BLANK, 3, 1'b1);

    // Reset mid-filter, then a fresh count.
    hold(CODES[8], 3);
    step(CODES[8], 1'b1, 1'b1, 1'b1);
    hold(CODES[8], 6);

    // Disabled samples inside a hold.
    for (int i = 0; i < 8; i++) step(CODES[4'hA], i[0], 1'b1, 1'b0);
    hold(BLANK, 4);

    // Randomized runs: mostly legal digits, some blanks and junk.
    for (int r = 0; r < 600; r++) begin
      logic [6:0] s;
      int len = $urandom_range(1, 6);
      int kind = $urandom_range(0, 9);
      if (kind < 6) s = CODES[$urandom_range(0, 15)];
      else if (kind < 8) s = BLANK;
      else s = 7'($urandom);
      for (int i = 0; i < len; i++)
        step(s, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
